// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle between the CPU/DMA masters, the arbiter and the slave side.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding masters and slave decoder.
interface wb_bus_arbiter_if #(
    parameter int NDMA = 2
);
    // CPU master side
    logic                   cpu_gnt;
    logic [15:0]            cpu_adr;
    logic [15:0]            cpu_dat_o;
    logic                   cpu_cyc;
    logic                   cpu_stb;
    logic                   cpu_we;
    logic [1:0]             cpu_sel;
    logic                   cpu_ack;
    // DMA master side, flattened per master
    logic [NDMA-1:0]        dma_req;
    logic [NDMA-1:0]        dma_gnt;
    logic [16*NDMA-1:0]     dma_adr;
    logic [16*NDMA-1:0]     dma_dat_o;
    logic [NDMA-1:0]        dma_cyc;
    logic [NDMA-1:0]        dma_stb;
    logic [NDMA-1:0]        dma_we;
    logic [2*NDMA-1:0]      dma_sel;
    logic [NDMA-1:0]        dma_ack;
    // Shared slave bus
    logic [15:0]            s_adr;
    logic [15:0]            s_dat_o;
    logic                   s_cyc;
    logic                   s_stb;
    logic                   s_we;
    logic [1:0]             s_sel;
    logic                   s_ack_i;
    logic                   bus_err;

    modport slave (
        input  cpu_adr, cpu_dat_o, cpu_cyc, cpu_stb, cpu_we, cpu_sel,
        input  dma_req, dma_adr, dma_dat_o, dma_cyc, dma_stb, dma_we, dma_sel,
        input  s_ack_i,
        output cpu_gnt, cpu_ack, dma_gnt, dma_ack,
        output s_adr, s_dat_o, s_cyc, s_stb, s_we, s_sel, bus_err
    );

    modport master (
        output cpu_adr, cpu_dat_o, cpu_cyc, cpu_stb, cpu_we, cpu_sel,
        output dma_req, dma_adr, dma_dat_o, dma_cyc, dma_stb, dma_we, dma_sel,
        output s_ack_i,
        input  cpu_gnt, cpu_ack, dma_gnt, dma_ack,
        input  s_adr, s_dat_o, s_cyc, s_stb, s_we, s_sel, bus_err
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Wishbone bus arbiter: shares one slave bus between the CPU and NDMA DMA masters.
// The CPU owns the bus by default. DMA masters get round-robin tenures, and
// each tenure is separated from CPU ownership by one dead cycle on each side.
// Optional feature macro: ARB_WATCHDOG_EN. It adds a strobe watchdog that
// forces an ack and pulses bus_err after TIMEOUT-1 unacknowledged clocks.
// Without the macro, bus_err is tied low.
module wb_bus_arbiter #(
    parameter int NDMA    = 2
`ifdef ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_bus_arbiter_if.slave      bus
);

    localparam int IW = (NDMA > 1) ? $clog2(NDMA) : 1;
    localparam logic [NDMA-1:0] ONE_HOT0 = NDMA'(1);

    typedef enum logic [1:0] {
        ST_CPU   = 2'd0,
        ST_GAP_D = 2'd1,
        ST_DMA   = 2'd2,
        ST_GAP_C = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_cpu_gnt;
    logic [NDMA-1:0]    r_dma_gnt;
    logic [IW-1:0]      r_winner;
    logic [IW-1:0]      r_rr;

    logic [15:0]        w_s_adr;
    logic [15:0]        w_s_dat;
    logic               w_s_cyc;
    logic               w_s_stb;
    logic               w_s_we;
    logic [1:0]         w_s_sel;
    logic               w_wd_ack;
    logic               w_ack_any;

    // First requester at or after the round-robin pointer.
    function automatic logic [IW-1:0] f_pick(input logic [NDMA-1:0] req,
                                             input logic [IW-1:0]   rr);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = rr;
        found = 1'b0;
        for (int i = 0; i < NDMA; i++) begin
            idx = (int'(rr) + i) % NDMA;
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Pointer value after a tenure of master w ends (w+1 mod NDMA).
    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] w);
        logic [IW-1:0] nxt;
        if (int'(w) >= NDMA - 1) begin
            nxt = {IW{1'b0}};
        end else begin
            nxt = w + IW'(1);
        end
        return nxt;
    endfunction

    // Ownership FSM. Grants, winner and round-robin pointer are all registered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_CPU;
            r_cpu_gnt <= 1'b1;
            r_dma_gnt <= {NDMA{1'b0}};
            r_winner  <= {IW{1'b0}};
            r_rr      <= {IW{1'b0}};
        end else begin
            case (r_state)
                ST_CPU: begin
                    // A CPU cycle in progress keeps the bus. DMA waits for it to end.
                    if ((|bus.dma_req) && !bus.cpu_cyc) begin
                        r_state   <= ST_GAP_D;
                        r_cpu_gnt <= 1'b0;
                        r_winner  <= f_pick(bus.dma_req, r_rr);
                    end else begin
                        r_state   <= ST_CPU;
                        r_cpu_gnt <= 1'b1;
                    end
                end
                ST_GAP_D: begin
                    if (bus.dma_req[r_winner]) begin
                        r_state   <= ST_DMA;
                        r_dma_gnt <= ONE_HOT0 << r_winner;
                    end else begin
                        // The winner withdrew during the gap, so hand back to the CPU.
                        r_state   <= ST_GAP_C;
                        r_dma_gnt <= {NDMA{1'b0}};
                    end
                end
                ST_DMA: begin
                    if (!bus.dma_req[r_winner] && !bus.dma_cyc[r_winner]) begin
                        r_state   <= ST_GAP_C;
                        r_dma_gnt <= {NDMA{1'b0}};
                        r_rr      <= f_next(r_winner);
                    end else begin
                        r_state   <= ST_DMA;
                    end
                end
                ST_GAP_C: begin
                    // The CPU always gets a tenure between DMA tenures.
                    r_state   <= ST_CPU;
                    r_cpu_gnt <= 1'b1;
                end
                default: begin
                    r_state   <= ST_CPU;
                    r_cpu_gnt <= 1'b1;
                    r_dma_gnt <= {NDMA{1'b0}};
                end
            endcase
        end
    end

    // Slave bus mux, driven from the registered owner select. Gap states drive an idle bus.
    always_comb begin
        w_s_adr = 16'h0000;
        w_s_dat = 16'h0000;
        w_s_cyc = 1'b0;
        w_s_stb = 1'b0;
        w_s_we  = 1'b0;
        w_s_sel = 2'b00;
        if (r_cpu_gnt) begin
            w_s_adr = bus.cpu_adr;
            w_s_dat = bus.cpu_dat_o;
            w_s_cyc = bus.cpu_cyc;
            w_s_stb = bus.cpu_stb;
            w_s_we  = bus.cpu_we;
            w_s_sel = bus.cpu_sel;
        end else if (r_state == ST_DMA) begin
            w_s_adr = bus.dma_adr[16*int'(r_winner) +: 16];
            w_s_dat = bus.dma_dat_o[16*int'(r_winner) +: 16];
            w_s_cyc = bus.dma_cyc[r_winner] & r_dma_gnt[r_winner];
            w_s_stb = bus.dma_stb[r_winner] & r_dma_gnt[r_winner];
            w_s_we  = bus.dma_we[r_winner];
            w_s_sel = bus.dma_sel[2*int'(r_winner) +: 2];
        end else begin
            w_s_cyc = 1'b0;
            w_s_stb = 1'b0;
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0]    r_wd_cnt;
    logic               r_bus_err;

    // Count unacknowledged strobe clocks. The forced ack lands on the clock the count reaches TIMEOUT-1.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wd_cnt  <= {WD_W{1'b0}};
            r_bus_err <= 1'b0;
        end else if (w_s_stb && !w_ack_any) begin
            r_wd_cnt  <= r_wd_cnt + WD_W'(1);
            if (r_wd_cnt == WD_W'(TIMEOUT - 2)) begin
                r_bus_err <= 1'b1;
            end else begin
                r_bus_err <= 1'b0;
            end
        end else begin
            r_wd_cnt  <= {WD_W{1'b0}};
            r_bus_err <= 1'b0;
        end
    end

    assign w_wd_ack    = r_bus_err;
    assign bus.bus_err = r_bus_err;
`else
    assign w_wd_ack    = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    assign w_ack_any   = bus.s_ack_i | w_wd_ack;

    assign bus.s_adr   = w_s_adr;
    assign bus.s_dat_o = w_s_dat;
    assign bus.s_cyc   = w_s_cyc;
    assign bus.s_stb   = w_s_stb;
    assign bus.s_we    = w_s_we;
    assign bus.s_sel   = w_s_sel;

    assign bus.cpu_gnt = r_cpu_gnt;
    assign bus.dma_gnt = r_dma_gnt;
    assign bus.cpu_ack = w_ack_any & r_cpu_gnt;
    assign bus.dma_ack = {NDMA{w_ack_any}} & r_dma_gnt;

endmodule
